// File: rtl/fancytimer_pkg.sv
// Shared types and constants for the fancy timer command stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fancytimer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_ACK,
        ST_GAP
    } state_e;

    localparam logic [3:0] START_PATTERN = 4'b1101;
    localparam int         FRAME_W       = 8;

    // Watchdog limit for one command: nominal timer count plus margin.
    // Computed in 32 bits; the caller saturates it into the counter width.
    function automatic logic [31:0] wd_limit(
        input logic [3:0]  delay,
        input int unsigned cycles_per_unit,
        input int unsigned margin
    );
        return (32'(delay) + 32'd1) * 32'(cycles_per_unit) + 32'(margin);
    endfunction

endpackage

// File: rtl/fancytimer_cmd_tx_watchdog.sv
// Cycle watchdog for the WAIT_DONE phase of fancytimer_cmd_tx.
// Latency: expired is combinational from the registered count and limit.
// Backpressure: none; counts whenever en is high, saturating at all-ones.
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   load        clear the count and capture limit (takes priority over en)
//   en          advance the count by one this cycle
//   limit       limit captured on load
//   expired     the cycle in progress is the limit-th enabled cycle (or later)
module fancytimer_watchdog #(
    parameter int WD_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            en,
    input  logic [WD_W-1:0] limit,
    output logic            expired
);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0] limit_q, limit_d;

    always_comb begin
        cnt_d   = cnt_q;
        limit_d = limit_q;
        if (load) begin
            cnt_d   = '0;
            limit_d = limit;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            limit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

    // cnt_q counts the enabled cycles already completed, so the current
    // cycle is number cnt_q+1. One extra bit keeps the +1 from wrapping.
    assign expired = (({1'b0, cnt_q} + (WD_W+1)'(1)) >= {1'b0, limit_q});

endmodule

// File: rtl/fancytimer_cmd_tx.sv
// Command stage for the fancy timer: serialises 1101+delay onto data, waits for done, acks.
// Latency: accept->first data bit 1 cycle, ->last bit 8 cycles; done->ack/resp_valid 1 cycle.
// Backpressure: req_ready is high only in IDLE; the source holds req_valid/req_delay until accepted.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   req_valid/req_ready/req_delay   command handshake, delay captured on accept
//   data           registered serial stream to the timer
//   done           timer finished (only looked at while waiting for it)
//   ack            registered one-cycle acknowledge to the timer
//   resp_valid     one-cycle completion pulse, resp_timeout set if the watchdog fired
module fancytimer_cmd_tx
    import fancytimer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_UNIT = 1000,
    parameter int unsigned WD_MARGIN       = 16,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int          WD_W            = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_delay,
    output logic       data,
    input  logic       done,
    output logic       ack,
    output logic       resp_valid,
    output logic       resp_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 data_q, data_d;
    logic                 ack_q, ack_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_timeout_q, resp_timeout_d;

    logic                 wd_load, wd_en, wd_expired;
    logic [31:0]          limit_full;
    logic [WD_W-1:0]      wd_limit_val;

    // The limit is taken from the latched frame and only captured by the
    // watchdog on load, so it is fixed for the whole WAIT_DONE phase.
    assign limit_full   = wd_limit(frame_q[3:0], CYCLES_PER_UNIT, WD_MARGIN);
    assign wd_limit_val = ((limit_full >> WD_W) != 32'd0) ? '1 : limit_full[WD_W-1:0];

    fancytimer_watchdog #(.WD_W(WD_W)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (wd_load),
        .en      (wd_en),
        .limit   (wd_limit_val),
        .expired (wd_expired)
    );

    always_comb begin
        state_d        = state_q;
        frame_d        = frame_q;
        bit_idx_d      = bit_idx_q;
        gap_cnt_d      = gap_cnt_q;
        data_d         = 1'b0;
        ack_d          = 1'b0;
        resp_valid_d   = 1'b0;
        resp_timeout_d = 1'b0;
        wd_load        = 1'b0;
        wd_en          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    // The MSB goes out on the accept edge so it is visible
                    // in the cycle right after the handshake.
                    frame_d   = {START_PATTERN, req_delay};
                    bit_idx_d = 3'(FRAME_W - 1);
                    data_d    = frame_d[FRAME_W-1];
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                // bit_idx_q names the bit currently on data.
                if (bit_idx_q == 3'd0) begin
                    wd_load = 1'b1;
                    state_d = ST_WAIT_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - 3'd1;
                    data_d    = frame_q[bit_idx_d];
                end
            end
            ST_WAIT_DONE: begin
                wd_en = 1'b1;
                // done is checked first so a coincident done beats expiry.
                if (done) begin
                    ack_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_ACK;
                end else if (wd_expired) begin
                    ack_d          = 1'b1;
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
                    state_d        = ST_ACK;
                end
            end
            ST_ACK: begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            frame_q        <= '0;
            bit_idx_q      <= '0;
            gap_cnt_q      <= '0;
            data_q         <= 1'b0;
            ack_q          <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_q        <= frame_d;
            bit_idx_q      <= bit_idx_d;
            gap_cnt_q      <= gap_cnt_d;
            data_q         <= data_d;
            ack_q          <= ack_d;
            resp_valid_q   <= resp_valid_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign data         = data_q;
    assign ack          = ack_q;
    assign resp_valid   = resp_valid_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: doc/fancytimer_cmd_tx.md
Name: fancytimer_cmd_tx

Overview:
Upstream command stage for the fancy timer. It accepts a 4-bit delay request over a valid/ready handshake and serialises the start pattern 1101 plus the delay (MSB first) onto the timer's `data` input. It then waits for the timer's `done`, returns `ack` and reports completion upstream. A watchdog flags a timer that never finishes.

Parameters:
CYCLES_PER_UNIT, 1000, timer cycles per delay unit; total count = (delay+1)*CYCLES_PER_UNIT
WD_MARGIN, 16, extra cycles tolerated beyond the nominal count before timeout
GAP_CYCLES, 2, minimum cycles of data=0 after ack before the next command (GAP_CYCLES>=1)
WD_W, 16, watchdog counter width; must hold 16*CYCLES_PER_UNIT+WD_MARGIN

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  command request
req_ready  out  1  block can accept (IDLE only)
req_delay  in  4  delay value, captured on accept
data  out  1  serial stream to timer, registered
done  in  1  timer finished
ack  out  1  acknowledge to timer, registered one-cycle pulse
resp_valid  out  1  one-cycle completion pulse
resp_timeout  out  1  qualifies resp_valid: 1 = watchdog expired

Behaviour:
- Reset values: data=0, ack=0, resp_valid=0, resp_timeout=0, req_ready=1, state=IDLE, counters=0. Reset mid-operation aborts immediately to IDLE. No ack is issued; the timer shares the same reset.
- States: IDLE, SEND, WAIT_DONE, ACK, GAP.
- IDLE: req_ready=1, data=0. On req_valid&&req_ready, latch frame {1,1,0,1,req_delay[3:0]}, set bit_idx=7, go to SEND.
- SEND: data = frame[bit_idx] registered.
  - First frame bit appears on the cycle after accept; one bit per cycle for 8 cycles.
  - After bit 0, data returns to 0 and state goes to WAIT_DONE; the watchdog clears and limit = (delay+1)*CYCLES_PER_UNIT + WD_MARGIN.
- WAIT_DONE: data=0 held, so no false start pattern. Watchdog increments each cycle.
  - If done=1, go to ACK with resp_timeout=0.
  - If the watchdog reaches the limit with done=0, go to ACK with resp_timeout=1.
  - If done and the limit coincide, done wins (resp_timeout=0).
- ACK: ack=1, resp_valid=1 for exactly one cycle. resp_timeout is valid in that cycle. Then GAP.
- GAP: data=0 for GAP_CYCLES cycles, then IDLE.
- done while not in WAIT_DONE is ignored.
- req_ready=0 in every state except IDLE. A req_valid outside IDLE is not accepted and the request must be held by the source.
- Watchdog arithmetic: unsigned, WD_W bits, saturating; the limit is computed once at WAIT_DONE entry.
- Latency from accept to first data bit is 1 cycle; accept to last bit is 8 cycles; done to ack is 1 cycle.

Decomposition:
- Package fancytimer_pkg holds:
  - the state enum;
  - START_PATTERN = 4'b1101;
  - FRAME_W = 8;
  - a function computing the watchdog limit from delay.
- One sub-module, fancytimer_watchdog: load/clear, enable, limit input, expired output.
- The serialiser and FSM stay in the top module.

Test Plan:
- Accept req_delay=5 -> data = 1,1,0,1,0,1,0,1 on cycles +1..+8, then 0. Check against the timer model:
  - counting high 6000 cycles;
  - ack and resp_valid exactly 1 cycle after done;
  - resp_timeout=0.
- req_delay=0, then req_delay=15 back-to-back with req_valid held:
  - counts of 1000 and 16000;
  - req_ready low from the first accept until GAP_CYCLES after the first ack;
  - second frame starts only after the gap.
- done tied 0, req_delay=0 -> resp_valid with resp_timeout=1 exactly 1016 cycles after WAIT_DONE entry; ack pulses once.
- done asserted in the same cycle the watchdog hits the limit -> resp_timeout=0.
- done pulsed during SEND -> ignored; frame completes unchanged.
- Reset asserted at SEND bit 3 -> next cycle: data=0, req_ready=1, no ack/resp_valid. A new req_delay=2 then runs normally (3000 cycles).
